cfu_rsp_sequencer: RTL and testbench
====================================

Name: cfu_rsp_sequencer

Overview:
- Responder end of the CPU custom-function-unit command/response interface.
- Accepts one command at a time over the cmd valid/ready handshake and holds the vector-length (VL) register.
- Sequences multi-element vector ops into the datapath one element per cycle, then returns a 32-bit result over the rsp valid/ready handshake.
- Sits between the CPU CFU port and the vector decoder/datapath.

Parameters:
- MAX_VL, 8, maximum vector length; a vsetvli request is clamped to this value.
- VL_W, 4, width of the VL register and element counter; must be at least clog2(MAX_VL)+1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  CPU command valid.
- cmd_ready  out  1  sequencer accepts a command this cycle.
- cmd_payload_function_id  in  10  bits [2:0] are the opcode; bits [7:3] are the wb/operand register index.
- cmd_payload_inputs_0  in  32  operand 0.
- cmd_payload_inputs_1  in  32  operand 1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  CPU accepts the response.
- rsp_payload_outputs_0  out  32  response data.
- op_step  out  1  datapath performs one element this cycle.
- op_code  out  3  latched opcode.
- op_reg  out  5  latched function_id[7:3].
- op_in0  out  32  latched inputs_0.
- op_in1  out  32  latched inputs_1.
- op_elem  out  VL_W  current element index.
- op_last  out  1  op_step is for the final element.
- vl  out  VL_W  current vector length.
- dp_result  in  32  combinational datapath result; valid in the op_last cycle.

Behaviour:
- Reset (asynchronous, applied immediately):
  - State IDLE.
  - vl=0, op_elem=0, all latched op_* registers=0, rsp_payload_outputs_0=0.
  - rsp_valid=0, op_step=0, op_last=0.
  - cmd_ready=1 once reset deasserts.
- States: IDLE, EXEC, RESP.
- cmd_ready=1 only in IDLE. A handshake is cmd_valid&cmd_ready on a rising edge. There is no accept during EXEC or RESP, so at least one IDLE cycle separates commands.
- On handshake: latch opcode, reg index, inputs_0 and inputs_1 into op_*. Then dispatch by opcode:
  - 0 (vsetvli): vl <= min(inputs_0, MAX_VL), with an unsigned compare on all 32 bits. Response data = new vl, zero-extended. Next state RESP.
  - 1 to 5 with vl==0: response data = 0. No op_step. Next state RESP.
  - 1 to 5 with vl>0: op_elem <= 0. Next state EXEC.
  - 6 and 7: no effect. Response data = 0. Next state RESP.
- EXEC:
  - op_step=1 every cycle; op_elem increments by 1 per cycle.
  - op_last=1 when op_elem==vl-1.
  - In the op_last cycle, the response data register loads:
    - dp_result if op_code==5 (vbacc);
    - otherwise vl, zero-extended.
  - Next state RESP.
  - EXEC lasts exactly vl cycles.
  - op_in0, op_in1, op_reg and op_code stay stable throughout EXEC.
- RESP:
  - rsp_valid=1, and rsp_payload_outputs_0 is held stable.
  - On rsp_ready=1: IDLE next cycle, and rsp_valid drops that edge.
  - rsp_ready is ignored outside RESP.
- Latency, accept edge to first rsp_valid cycle:
  - vsetvli / no-op / vl==0: 1 cycle.
  - Vector op: vl+1 cycles.
- vl persists across commands and changes only on vsetvli or reset.
- op_step, op_last and op_elem carry no meaning outside EXEC. op_step=0 and op_last=0 outside EXEC.
- Reset during EXEC or RESP: the operation is aborted with no response, and vl is cleared to 0.
- cmd_valid during a non-IDLE state is ignored; the CPU must hold it until cmd_ready.

Test Plan:
- Reset, then vsetvli with inputs_0=5 -> cmd_ready 1 in the accept cycle; rsp_valid the next cycle with outputs_0=5; vl=5.
- vsetvli with inputs_0=0x0000_0014, MAX_VL=8 -> outputs_0=8, vl=8. A separate case with inputs_0=0xFFFF_FFFF also returns 8.
- vl=3, then vmul (opcode 4, function_id[7:3]=9) -> 3 op_step cycles with op_elem 0,1,2 and op_last only on element 2; op_reg=9 throughout; rsp outputs_0=3 one cycle later.
- vl=4, then vbacc (opcode 5) with dp_result=0xDEAD_BEEF in the op_last cycle -> rsp outputs_0=0xDEADBEEF.
- rsp_ready held low for 4 cycles in RESP -> rsp_valid and data held stable; cmd_ready=0; a new cmd_valid is not accepted until one cycle after the rsp handshake.
- vl=0 then vload -> no op_step, and rsp outputs_0=0 after 1 cycle.
- Reset asserted in the 2nd EXEC cycle of a vl=8 op -> outputs return to reset values immediately; no rsp_valid; vl=0.

Source files
------------

// File: rtl/cfu_rsp_sequencer.sv
// -----------------------------------------------------------------------------
// cfu_rsp_sequencer
//
// Responder end of the CPU custom-function-unit (CFU) command/response port.
// Accepts one command at a time, keeps the vector-length register (vl), steps
// multi-element vector ops through the datapath one element per cycle and
// returns a single 32-bit result on the response handshake.
//
// Ports
//   clk, reset                  clock (rising edge), async active-high reset
//   cmd_valid / cmd_ready       command handshake from the CPU
//   cmd_payload_function_id     [2:0] opcode, [7:3] register index, [9:8] unused
//   cmd_payload_inputs_0/1      32-bit operands
//   rsp_valid / rsp_ready       response handshake to the CPU
//   rsp_payload_outputs_0       32-bit response data
//   op_step, op_last, op_elem   per-element strobe, final-element flag, index
//   op_code, op_reg, op_in0/1   command fields latched for the datapath
//   vl                          current vector length
//   dp_result                   datapath result, sampled on the op_last cycle
// -----------------------------------------------------------------------------
module cfu_rsp_sequencer #(
  parameter int MAX_VL = 8,
  parameter int VL_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [9:0]      cmd_payload_function_id,
  input  logic [31:0]     cmd_payload_inputs_0,
  input  logic [31:0]     cmd_payload_inputs_1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_payload_outputs_0,
  output logic            op_step,
  output logic [2:0]      op_code,
  output logic [4:0]      op_reg,
  output logic [31:0]     op_in0,
  output logic [31:0]     op_in1,
  output logic [VL_W-1:0] op_elem,
  output logic            op_last,
  output logic [VL_W-1:0] vl,
  input  logic [31:0]     dp_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  localparam logic [2:0]  OP_VSETVLI = 3'd0;
  localparam logic [2:0]  OP_VBACC   = 3'd5;
  localparam logic [31:0] MAX_VL_32  = 32'(MAX_VL);

  state_e            state_q, state_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic [VL_W-1:0]   op_elem_q, op_elem_d;
  logic [2:0]        op_code_q, op_code_d;
  logic [4:0]        op_reg_q, op_reg_d;
  logic [31:0]       op_in0_q, op_in0_d;
  logic [31:0]       op_in1_q, op_in1_d;
  logic [31:0]       rsp_data_q, rsp_data_d;

  logic [2:0]        cmd_opcode;
  logic [VL_W-1:0]   vl_clamped;
  logic              last_elem;
  logic              unused_fid_bits;

  assign cmd_opcode      = cmd_payload_function_id[2:0];
  assign unused_fid_bits = ^cmd_payload_function_id[9:8];

  // Full 32-bit unsigned compare so huge requests clamp instead of wrapping.
  assign vl_clamped = (cmd_payload_inputs_0 > MAX_VL_32) ? VL_W'(MAX_VL)
                                                         : cmd_payload_inputs_0[VL_W-1:0];

  assign last_elem = (op_elem_q == (vl_q - VL_W'(1)));

  assign cmd_ready             = (state_q == S_IDLE);
  assign rsp_valid             = (state_q == S_RESP);
  assign op_step               = (state_q == S_EXEC);
  assign op_last               = (state_q == S_EXEC) && last_elem;
  assign rsp_payload_outputs_0 = rsp_data_q;
  assign op_code               = op_code_q;
  assign op_reg                = op_reg_q;
  assign op_in0                = op_in0_q;
  assign op_in1                = op_in1_q;
  assign op_elem               = op_elem_q;
  assign vl                    = vl_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    vl_d       = vl_q;
    op_elem_d  = op_elem_q;
    op_code_d  = op_code_q;
    op_reg_d   = op_reg_q;
    op_in0_d   = op_in0_q;
    op_in1_d   = op_in1_q;
    rsp_data_d = rsp_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_code_d = cmd_opcode;
          op_reg_d  = cmd_payload_function_id[7:3];
          op_in0_d  = cmd_payload_inputs_0;
          op_in1_d  = cmd_payload_inputs_1;
          unique case (cmd_opcode)
            OP_VSETVLI: begin
              vl_d       = vl_clamped;
              rsp_data_d = {{(32-VL_W){1'b0}}, vl_clamped};
              state_d    = S_RESP;
            end
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5: begin
              if (vl_q == '0) begin
                // Empty vector: answer immediately without touching the datapath.
                rsp_data_d = '0;
                state_d    = S_RESP;
              end else begin
                op_elem_d = '0;
                state_d   = S_EXEC;
              end
            end
            default: begin
              rsp_data_d = '0;
              state_d    = S_RESP;
            end
          endcase
        end
      end

      S_EXEC: begin
        op_elem_d = op_elem_q + VL_W'(1);
        if (last_elem) begin
          // Only the accumulate op returns datapath data; the rest report vl.
          rsp_data_d = (op_code_q == OP_VBACC) ? dp_result
                                               : {{(32-VL_W){1'b0}}, vl_q};
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: reset clears vl as well, so an aborted op leaves the unit with an
  // empty vector length rather than a stale one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      vl_q       <= '0;
      op_elem_q  <= '0;
      op_code_q  <= '0;
      op_reg_q   <= '0;
      op_in0_q   <= '0;
      op_in1_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      vl_q       <= vl_d;
      op_elem_q  <= op_elem_d;
      op_code_q  <= op_code_d;
      op_reg_q   <= op_reg_d;
      op_in0_q   <= op_in0_d;
      op_in1_q   <= op_in1_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_cfu_rsp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cfu_rsp_sequencer
//
// Self-checking bench for cfu_rsp_sequencer. A command-level reference model
// (vl as an integer, expected element count and response computed from the
// command rules) predicts every observation. Inputs are driven and outputs
// sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_cfu_rsp_sequencer;

  localparam int MAX_VL = 8;
  localparam int VL_W   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [9:0]      cmd_payload_function_id;
  logic [31:0]     cmd_payload_inputs_0;
  logic [31:0]     cmd_payload_inputs_1;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_payload_outputs_0;
  logic            op_step;
  logic [2:0]      op_code;
  logic [4:0]      op_reg;
  logic [31:0]     op_in0;
  logic [31:0]     op_in1;
  logic [VL_W-1:0] op_elem;
  logic            op_last;
  logic [VL_W-1:0] vl;
  logic [31:0]     dp_result;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int          vl_m = 0;
  logic [31:0] dp_vals [32];

  cfu_rsp_sequencer #(.MAX_VL(MAX_VL), .VL_W(VL_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .op_step                 (op_step),
    .op_code                 (op_code),
    .op_reg                  (op_reg),
    .op_in0                  (op_in0),
    .op_in1                  (op_in1),
    .op_elem                 (op_elem),
    .op_last                 (op_last),
    .vl                      (vl),
    .dp_result               (dp_result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and complete the cmd handshake. Returns 1 time unit after
  // the accept edge.
  task automatic issue(input string name, input logic [2:0] op, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] b);
    int w;
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {2'($urandom_range(0, 3)), r, op};
    cmd_payload_inputs_0    = a;
    cmd_payload_inputs_1    = b;
    rsp_ready               = 1'b0;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // Run one full command against the model: handshake, element stepping,
  // response with `hold` cycles of back-pressure, then response handshake.
  // With pend set, a vsetvli(2) is presented while the response is stalled.
  task automatic run_cmd(input string name, input logic [2:0] op, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] b, input int hold,
                         input bit pend, input bit rand_ready, input bit fix_last,
                         input logic [31:0] last_dp);
    int          exp_steps;
    logic [31:0] exp_data;
    int          lat;
    int          steps;

    for (int i = 0; i < 32; i++) dp_vals[i] = $urandom;

    exp_steps = 0;
    exp_data  = 32'd0;
    if (op == 3'd0) begin
      vl_m     = (a > 32'(MAX_VL)) ? MAX_VL : int'(a);
      exp_data = 32'(vl_m);
    end else if (op <= 3'd5 && vl_m > 0) begin
      if (fix_last) dp_vals[vl_m-1] = last_dp;
      exp_steps = vl_m;
      exp_data  = (op == 3'd5) ? dp_vals[vl_m-1] : 32'(vl_m);
    end

    issue(name, op, r, a, b);

    lat   = 1;
    steps = 0;
    while (rsp_valid !== 1'b1 && lat <= 20) begin
      n_checks++;
      if (op_step !== 1'b1 || op_elem !== VL_W'(lat - 1) ||
          op_last !== (lat == exp_steps)) begin
        n_errors++;
        $display("FAIL %s step %0d: got step=%b elem=%0d last=%b want 1/%0d/%b",
                 name, lat, op_step, op_elem, op_last, lat - 1, lat == exp_steps);
      end
      n_checks++;
      if (op_reg !== r || op_code !== op || op_in0 !== a || op_in1 !== b || cmd_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL %s latched fields: got reg=%0d code=%0d in0=%h in1=%h rdy=%b want %0d/%0d/%h/%h/0",
                 name, op_reg, op_code, op_in0, op_in1, cmd_ready, r, op, a, b);
      end
      dp_result = dp_vals[lat - 1];
      if (rand_ready) rsp_ready = 1'($urandom);
      steps++;
      tick();
      lat++;
    end
    rsp_ready = 1'b0;

    n_checks++;
    if (steps !== exp_steps) begin
      n_errors++;
      $display("FAIL %s step count: got %0d want %0d", name, steps, exp_steps);
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || op_step !== 1'b0 || op_last !== 1'b0) begin
      n_errors++;
      $display("FAIL %s response latency: got valid=%b step=%b last=%b after %0d cycles want 1/0/0 after %0d",
               name, rsp_valid, op_step, op_last, lat, exp_steps + 1);
    end
    n_checks++;
    if (rsp_payload_outputs_0 !== exp_data || vl !== VL_W'(vl_m)) begin
      n_errors++;
      $display("FAIL %s response data: got data=%h vl=%0d want %h/%0d",
               name, rsp_payload_outputs_0, vl, exp_data, vl_m);
    end

    if (pend) begin
      cmd_valid               = 1'b1;
      cmd_payload_function_id = 10'd0;
      cmd_payload_inputs_0    = 32'd2;
      cmd_payload_inputs_1    = 32'd0;
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_payload_outputs_0 !== exp_data || cmd_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL %s stall %0d: got valid=%b data=%h rdy=%b want 1/%h/0",
                 name, h, rsp_valid, rsp_payload_outputs_0, cmd_ready, exp_data);
      end
    end

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s after rsp handshake: got valid=%b rdy=%b want 0/1",
               name, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    dp_result = 32'd0;
    cmd_payload_function_id = 10'd0;
    cmd_payload_inputs_0    = 32'd0;
    cmd_payload_inputs_1    = 32'd0;
    repeat (3) tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || op_step !== 1'b0 || op_last !== 1'b0 || vl !== '0 ||
        op_elem !== '0 || op_code !== '0 || op_reg !== '0 || op_in0 !== '0 ||
        op_in1 !== '0 || rsp_payload_outputs_0 !== '0) begin
      n_errors++;
      $display("FAIL reset values: got valid=%b step=%b last=%b vl=%0d elem=%0d code=%0d reg=%0d in0=%h in1=%h data=%h want all 0",
               rsp_valid, op_step, op_last, vl, op_elem, op_code, op_reg, op_in0, op_in1,
               rsp_payload_outputs_0);
    end
    reset = 1'b0;
    vl_m  = 0;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_vsetvli();
    run_cmd("vsetvli_5",    3'd0, 5'd0, 32'd5,         32'h1234_5678, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_cmd("vsetvli_0x14", 3'd0, 5'd1, 32'h0000_0014, 32'd0,         0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_cmd("vsetvli_max",  3'd0, 5'd2, 32'hFFFF_FFFF, 32'd0,         0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_cmd("vsetvli_8",    3'd0, 5'd3, 32'd8,         32'd0,         0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_vmul();
    run_cmd("vmul_setvl", 3'd0, 5'd0, 32'd3,         32'd0,         0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_cmd("vmul",       3'd4, 5'd9, 32'hA5A5_0001, 32'h5A5A_0002, 0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_vbacc();
    run_cmd("vbacc_setvl", 3'd0, 5'd0, 32'd4,        32'd0,       0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_cmd("vbacc",       3'd5, 5'd7, 32'h0000_1111, 32'h2222_0000, 0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
  endtask

  task automatic test_backpressure();
    run_cmd("stall_op", 3'd2, 5'd4, 32'h0BAD_F00D, 32'h0000_0042, 4, 1'b1, 1'b0, 1'b0, 32'd0);
    // The pending vsetvli(2) was refused until the response handshake; it is
    // accepted on the following edge.
    vl_m = 2;
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_payload_outputs_0 !== 32'd2 || vl !== VL_W'(2)) begin
      n_errors++;
      $display("FAIL pending cmd: got valid=%b data=%h vl=%0d want 1/00000002/2",
               rsp_valid, rsp_payload_outputs_0, vl);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_noop();
    run_cmd("noop6", 3'd6, 5'd3, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_cmd("noop7", 3'd7, 5'd5, 32'd1,         32'd2, 1, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_reset_abort();
    run_cmd("abort_setvl", 3'd0, 5'd0, 32'd8, 32'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    issue("abort_op", 3'd1, 5'd6, 32'h1357_9BDF, 32'h2468_ACE0);
    tick();
    n_checks++;
    if (op_step !== 1'b1 || op_elem !== VL_W'(1)) begin
      n_errors++;
      $display("FAIL abort second exec cycle: got step=%b elem=%0d want 1/1", op_step, op_elem);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (op_step !== 1'b0 || rsp_valid !== 1'b0 || vl !== '0 || op_elem !== '0 ||
        op_code !== '0 || op_reg !== '0 || op_in0 !== '0 || rsp_payload_outputs_0 !== '0) begin
      n_errors++;
      $display("FAIL abort async reset: got step=%b valid=%b vl=%0d elem=%0d code=%0d reg=%0d in0=%h data=%h want all 0",
               op_step, rsp_valid, vl, op_elem, op_code, op_reg, op_in0, rsp_payload_outputs_0);
    end
    #2;
    reset = 1'b0;
    vl_m  = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (rsp_valid !== 1'b0 || op_step !== 1'b0 || cmd_ready !== 1'b1 || vl !== '0) begin
        n_errors++;
        $display("FAIL abort idle %0d: got valid=%b step=%b rdy=%b vl=%0d want 0/0/1/0",
                 i, rsp_valid, op_step, cmd_ready, vl);
      end
    end
  endtask

  task automatic test_vl_zero();
    run_cmd("vload_vl0", 3'd1, 5'd8, 32'h0000_0100, 32'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_cmd("vbacc_vl0", 3'd5, 5'd2, 32'd0,         32'd0, 2, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd0) begin
        unique case ($urandom_range(0, 2))
          0:       a = 32'($urandom_range(0, 12));
          1:       a = $urandom;
          default: a = 32'($urandom_range(1, MAX_VL));
        endcase
      end else begin
        a = $urandom;
      end
      run_cmd("random", op, 5'($urandom_range(0, 31)), a, $urandom,
              $urandom_range(0, 3), 1'b0, 1'b1, 1'b0, 32'd0);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_vsetvli();
    test_vmul();
    test_vbacc();
    test_backpressure();
    test_noop();
    test_reset_abort();
    test_vl_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
